// File: rtl/sbox_if.sv
// sbox_if -- bundles the substitution-layer data signals of sbox.
//
// Signals:
//   inText     32  substitution-layer input word (eight 4-bit lanes)
//   outText    32  combinational forward substitution of inText
//   outInv     32  combinational inverse substitution of inText
//   outText_q  32  registered copy of outText
//   valid_q     1  outText_q holds a substitution result rather than the reset value
//
// Modports:
//   master  the side that supplies inText and observes the results
//   slave   the sbox itself
interface sbox_if;
    logic [31:0] inText;
    logic [31:0] outText;
    logic [31:0] outInv;
    logic [31:0] outText_q;
    logic        valid_q;

    modport master (
        output inText,
        input  outText,
        input  outInv,
        input  outText_q,
        input  valid_q
    );

    modport slave (
        input  inText,
        output outText,
        output outInv,
        output outText_q,
        output valid_q
    );
endinterface

// File: rtl/sbox.sv
// sbox -- 32-bit 4-bit-lane substitution layer.
//
// Eight independent lanes each pass through the same 16-entry table.
// The forward and inverse layers are purely combinational. A registered
// copy of the forward layer is captured every clock edge.
//
// Ports:
//   clk    input   clock, registered outputs update on its rising edge
//   reset  input   synchronous, active-high; clears outText_q and valid_q
//   bus    sbox_if.slave
//          inText (in), outText/outInv (combinational out),
//          outText_q/valid_q (registered out)
module sbox (
    input  logic  clk,
    input  logic  reset,
    sbox_if.slave bus
);

    // Forward lane table.
    function automatic logic [3:0] s_fwd(input logic [3:0] x);
        logic [3:0] s;
        case (x)
            4'h0:    s = 4'hC;
            4'h1:    s = 4'h5;
            4'h2:    s = 4'h6;
            4'h3:    s = 4'hB;
            4'h4:    s = 4'h9;
            4'h5:    s = 4'h0;
            4'h6:    s = 4'hA;
            4'h7:    s = 4'hD;
            4'h8:    s = 4'h3;
            4'h9:    s = 4'hE;
            4'hA:    s = 4'hF;
            4'hB:    s = 4'h8;
            4'hC:    s = 4'h4;
            4'hD:    s = 4'h7;
            4'hE:    s = 4'h1;
            default: s = 4'h2;
        endcase
        return s;
    endfunction

    // Inverse lane table; undoes s_fwd for every nibble.
    function automatic logic [3:0] s_inv(input logic [3:0] x);
        logic [3:0] s;
        case (x)
            4'h0:    s = 4'h5;
            4'h1:    s = 4'hE;
            4'h2:    s = 4'hF;
            4'h3:    s = 4'h8;
            4'h4:    s = 4'hC;
            4'h5:    s = 4'h1;
            4'h6:    s = 4'h2;
            4'h7:    s = 4'hD;
            4'h8:    s = 4'hB;
            4'h9:    s = 4'h4;
            4'hA:    s = 4'h6;
            4'hB:    s = 4'h3;
            4'hC:    s = 4'h0;
            4'hD:    s = 4'h7;
            4'hE:    s = 4'h9;
            default: s = 4'hA;
        endcase
        return s;
    endfunction

    logic [31:0] fwd_word;
    logic [31:0] inv_word;
    logic [31:0] text_q;
    logic        valid_reg;

    // Each lane maps in place; no lane ever sees another lane's bits.
    always_comb begin
        fwd_word = '0;
        inv_word = '0;
        for (int k = 0; k < 8; k++) begin
            fwd_word[4*k +: 4] = s_fwd(bus.inText[4*k +: 4]);
            inv_word[4*k +: 4] = s_inv(bus.inText[4*k +: 4]);
        end
    end

    // Captures every cycle with no enable; reset wins over capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            text_q    <= '0;
            valid_reg <= 1'b0;
        end else begin
            text_q    <= fwd_word;
            valid_reg <= 1'b1;
        end
    end

    assign bus.outText   = fwd_word;
    assign bus.outInv    = inv_word;
    assign bus.outText_q = text_q;
    assign bus.valid_q   = valid_reg;

endmodule

// File: tb/tb_sbox.sv
// tb_sbox -- self-checking bench for sbox.
//
// A driver applies one input word per cycle, checks the combinational
// outputs directly against a table-driven reference, and queues the
// registered result expected after the next edge. A monitor pops that
// queue one edge later and compares outText_q/valid_q.
module tb_sbox;

    logic clk;
    logic reset;

    sbox_if bus ();

    sbox dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected {valid_q, outText_q} after the next rising edge.
    logic [32:0] expQ[$];
    logic [32:0] lastExp = '0;

    logic [3:0] fwdTable [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                  4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    // Reference forward layer: look each nibble up in the table.
    function automatic logic [31:0] modelFwd(input logic [31:0] w);
        logic [31:0] r = '0;
        for (int k = 0; k < 8; k++)
            r |= 32'(fwdTable[(w >> (4*k)) & 32'hF]) << (4*k);
        return r;
    endfunction

    // Reference inverse layer: search the forward table for the preimage.
    function automatic logic [31:0] modelInv(input logic [31:0] w);
        logic [31:0] r = '0;
        for (int k = 0; k < 8; k++) begin
            logic [3:0] nib = 4'((w >> (4*k)) & 32'hF);
            for (int j = 0; j < 16; j++)
                if (fwdTable[j] == nib) r |= 32'(j) << (4*k);
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drive one word for one cycle, check the combinational outputs and
    // queue the registered result for the monitor.
    task automatic applyStimulus(input logic [31:0] word, input logic rst);
        @(posedge clk);
        #2;
        bus.inText = word;
        reset      = rst;
        #1;
        checkOutput("outText", bus.outText, modelFwd(word));
        checkOutput("outInv",  bus.outInv,  modelInv(word));
        expQ.push_back(rst ? 33'h0 : {1'b1, modelFwd(word)});
    endtask

    // Change the input twice within one cycle; the registered outputs must
    // keep what the previous edge captured while the combinational ones track.
    task automatic midCycleGlitch(input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #2;
        reset      = 1'b0;
        bus.inText = a;
        #1;
        checkOutput("glitch_outText_a", bus.outText, modelFwd(a));
        #1;
        bus.inText = b;
        #1;
        checkOutput("glitch_outText_b", bus.outText,   modelFwd(b));
        checkOutput("glitch_hold_q",    bus.outText_q, lastExp[31:0]);
        checkOutput("glitch_hold_v",    32'(bus.valid_q), 32'(lastExp[32]));
        expQ.push_back({1'b1, modelFwd(b)});
    endtask

    // Monitor: one edge after each queued expectation, compare the registers.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                lastExp = expQ.pop_front();
                checkOutput("outText_q", bus.outText_q, lastExp[31:0]);
                checkOutput("valid_q",   32'(bus.valid_q), 32'(lastExp[32]));
            end
        end
    end

    // Watchdog against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset      = 1'b1;
        bus.inText = '0;

        // Reset held for two edges; combinational path keeps tracking.
        // Lane value 8 maps to 3, so 12345678 maps to 56B90AD3.
        applyStimulus(32'h12345678, 1'b1);
        checkOutput("rst_outText_0", bus.outText, 32'h56B90AD3);
        applyStimulus(32'h12345678, 1'b1);
        checkOutput("rst_outText_1", bus.outText, 32'h56B90AD3);
        applyStimulus(32'h12345678, 1'b0);

        // Directed reference vectors.
        applyStimulus(32'h00000000, 1'b0);
        checkOutput("zero_fwd", bus.outText, 32'hCCCCCCCC);
        checkOutput("zero_inv", bus.outInv,  32'h55555555);
        applyStimulus(32'h01234567, 1'b0);
        checkOutput("seq_lo_fwd", bus.outText, 32'hC56B90AD);
        applyStimulus(32'h89ABCDEF, 1'b0);
        checkOutput("seq_hi_fwd", bus.outText, 32'h3EF84712);
        applyStimulus(32'hFFFFFFFF, 1'b0);
        checkOutput("ones_fwd", bus.outText, 32'h22222222);
        checkOutput("ones_inv", bus.outInv,  32'hAAAAAAAA);
        applyStimulus(32'hC56B90AD, 1'b0);
        checkOutput("round_trip_inv", bus.outInv, 32'h01234567);

        // Single-lane sweep, other lanes zero.
        for (int k = 0; k < 8; k++)
            for (int v = 0; v < 16; v++)
                applyStimulus(32'(v) << (4*k), 1'b0);

        // Toggling input with a one-edge reset in the middle.
        applyStimulus(32'hA5A5A5A5, 1'b0);
        applyStimulus(32'h5A5A5A5A, 1'b0);
        applyStimulus(32'hA5A5A5A5, 1'b1);
        applyStimulus(32'h5A5A5A5A, 1'b0);
        applyStimulus(32'hA5A5A5A5, 1'b0);

        midCycleGlitch(32'hDEADBEEF, 32'h0F1E2D3C);
        applyStimulus(32'h76543210, 1'b0);

        // Random words with occasional reset pulses.
        for (int i = 0; i < 200; i++)
            applyStimulus($urandom, ($urandom_range(0, 15) == 0));

        applyStimulus(32'h13579BDF, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
